bitwise_gate_accum: RTL and testbench

//  Parametrised successor to the two-input combinational gates: combines NUM_IN operands of WIDTH bits

---
 rtl/gate_pkg.sv | 44 ++++
 rtl/bitwise_gate_accum_if.sv | 40 ++++
 rtl/gate_reduce.sv | 24 ++
 rtl/bitwise_gate_accum.sv | 136 +++++++++++++
 tb/tb_bitwise_gate_accum.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/gate_pkg.sv
// Shared types and op decoding for the bitwise gate accumulator.
// Ops 3-5 are the inverted forms of 0-2; ops 6-7 are reserved.
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_e;

    function automatic logic is_inv(op_e op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic is_rsv(op_e op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

    // Reserved ops reduce with AND; their data is forced to zero at the output anyway.
    function automatic base_e base_of(op_e op);
        case (op)
            OP_OR, OP_NOR:   return BASE_OR;
            OP_XOR, OP_XNOR: return BASE_XOR;
            default:         return BASE_AND;
        endcase
    endfunction

endpackage

// File: rtl/bitwise_gate_accum_if.sv
// Valid/ready stream bundle for bitwise_gate_accum (input beats and registered result).
// GATE_POPCOUNT_EN adds the out_pop result field.
interface bitwise_gate_accum_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_IN*WIDTH-1:0]  in_data;
    logic [2:0]               in_op;
    logic                     in_acc;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [CNT_W-1:0]         out_beats;
    logic                     out_err;
`ifdef GATE_POPCOUNT_EN
    logic [$clog2(WIDTH+1)-1:0] out_pop;

    modport master (
        output in_valid, in_data, in_op, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_err, out_pop
    );
    modport slave (
        input  in_valid, in_data, in_op, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_err, out_pop
    );
`else
    modport master (
        output in_valid, in_data, in_op, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_err
    );
    modport slave (
        input  in_valid, in_data, in_op, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_err
    );
`endif
endinterface

// File: rtl/gate_reduce.sv
// Combinational reduction of NUM_IN packed WIDTH-bit operands with one base op.
module gate_reduce
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  base_e                    base,
    input  logic [NUM_IN*WIDTH-1:0]  data,
    output logic [WIDTH-1:0]         r
);

    always_comb begin
        r = data[0 +: WIDTH];
        for (int k = 1; k < NUM_IN; k++) begin
            case (base)
                BASE_OR:  r = r | data[k*WIDTH +: WIDTH];
                BASE_XOR: r = r ^ data[k*WIDTH +: WIDTH];
                default:  r = r & data[k*WIDTH +: WIDTH];
            endcase
        end
    end

endmodule

// File: rtl/bitwise_gate_accum.sv
// Registered NUM_IN-operand logic gate stage with optional multi-beat accumulation.
// GATE_POPCOUNT_EN adds a registered population count of the result (out_pop).
module bitwise_gate_accum
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bitwise_gate_accum_if.slave  bus
);

    state_e             state, state_n;
    op_e                op_q, op_q_n, op_in;
    base_e              red_base, q_base;
    logic [WIDTH-1:0]   acc, acc_n, r, fold;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic               accept, load;
    logic [WIDTH-1:0]   res_data;
    logic [CNT_W-1:0]   res_beats;
    logic               res_err;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign op_in        = op_e'(bus.in_op);
    assign q_base       = base_of(op_q);
    // Mid-packet beats reduce with the op latched at packet start, not the live in_op.
    assign red_base     = (state == IDLE) ? base_of(op_in) : q_base;
    assign cnt_inc      = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    gate_reduce #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_reduce (
        .base (red_base),
        .data (bus.in_data),
        .r    (r)
    );

    always_comb begin
        case (q_base)
            BASE_OR:  fold = acc | r;
            BASE_XOR: fold = acc ^ r;
            default:  fold = acc & r;
        endcase
    end

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        op_q_n    = op_q;
        cnt_n     = cnt;
        load      = 1'b0;
        res_data  = '0;
        res_beats = '0;
        res_err   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_acc && !bus.in_last) begin
                        state_n = ACCUM;
                        acc_n   = r;
                        op_q_n  = op_in;
                        cnt_n   = CNT_W'(1);
                    end else begin
                        load      = 1'b1;
                        res_data  = is_rsv(op_in) ? '0 : (is_inv(op_in) ? ~r : r);
                        res_beats = CNT_W'(1);
                        res_err   = is_rsv(op_in);
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_n = fold;
                    cnt_n = cnt_inc;
                    if (bus.in_last) begin
                        state_n   = IDLE;
                        load      = 1'b1;
                        res_data  = is_rsv(op_q) ? '0 : (is_inv(op_q) ? ~fold : fold);
                        res_beats = cnt_inc;
                        res_err   = is_rsv(op_q);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            op_q          <= OP_AND;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_beats <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            op_q  <= op_q_n;
            cnt   <= cnt_n;
            // load implies accept, so a pending result is never overwritten unconsumed.
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= res_data;
                bus.out_beats <= res_beats;
                bus.out_err   <= res_err;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef GATE_POPCOUNT_EN
    localparam int POP_W = $clog2(WIDTH+1);
    logic [POP_W-1:0] pop_n;

    always_comb begin
        pop_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_n = pop_n + POP_W'(res_data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_pop <= '0;
        end else if (load) begin
            bus.out_pop <= pop_n;
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_gate_accum.sv
// Directed bench for bitwise_gate_accum: an 8-bit instance and a 1-bit truth-table instance.
module tb_bitwise_gate_accum;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    bitwise_gate_accum_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) b8 ();
    bitwise_gate_accum_if #(.WIDTH(1), .NUM_IN(2), .CNT_W(8)) b1 ();

    bitwise_gate_accum #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    bitwise_gate_accum #(.WIDTH(1), .NUM_IN(2), .CNT_W(8)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat8(input logic [7:0] d1, input logic [7:0] d0, input logic [2:0] op,
                         input logic acc, input logic last);
        b8.in_valid = 1'b1;
        b8.in_data  = {d1, d0};
        b8.in_op    = op;
        b8.in_acc   = acc;
        b8.in_last  = last;
    endtask

    task automatic chk_out8(input string tag, input logic [7:0] d, input logic [7:0] beats,
                            input logic err);
        chk({tag, "_valid"}, 32'(b8.out_valid), 32'd1);
        chk({tag, "_data"},  32'(b8.out_data),  32'(d));
        chk({tag, "_beats"}, 32'(b8.out_beats), 32'(beats));
        chk({tag, "_err"},   32'(b8.out_err),   32'(err));
    endtask

    initial begin
        logic a, b, e1;

        rst = 1'b1;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.in_op = '0; b8.in_acc = 1'b0;
        b8.in_last = 1'b0;  b8.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_op = '0; b1.in_acc = 1'b0;
        b1.in_last = 1'b0;  b1.out_ready = 1'b1;

        // Reset
        tick();
        tick();
        chk("rst_valid",  32'(b8.out_valid), 32'd0);
        chk("rst_data",   32'(b8.out_data),  32'h00);
        chk("rst_beats",  32'(b8.out_beats), 32'd0);
        chk("rst_err",    32'(b8.out_err),   32'd0);
        chk("rst_ready",  32'(b8.in_ready),  32'd1);
`ifdef GATE_POPCOUNT_EN
        chk("rst_pop",    32'(b8.out_pop),   32'd0);
`endif
        rst = 1'b0;

        // Single beats, operand1=F0, operand0=0F
        beat8(8'hF0, 8'h0F, 3'd1, 1'b0, 1'b0); tick(); chk_out8("or",   8'hFF, 8'd1, 1'b0);
`ifdef GATE_POPCOUNT_EN
        chk("or_pop", 32'(b8.out_pop), 32'd8);
`endif
        beat8(8'hF0, 8'h0F, 3'd0, 1'b0, 1'b0); tick(); chk_out8("and",  8'h00, 8'd1, 1'b0);
        beat8(8'hF0, 8'h0F, 3'd4, 1'b0, 1'b0); tick(); chk_out8("nor",  8'h00, 8'd1, 1'b0);
        beat8(8'hF0, 8'h0F, 3'd2, 1'b0, 1'b0); tick(); chk_out8("xor",  8'hFF, 8'd1, 1'b0);
        beat8(8'hF0, 8'h0F, 3'd3, 1'b0, 1'b0); tick(); chk_out8("nand", 8'hFF, 8'd1, 1'b0);
        beat8(8'hC3, 8'h81, 3'd5, 1'b0, 1'b0); tick(); chk_out8("xnor", 8'hBD, 8'd1, 1'b0);
        b8.in_valid = 1'b0; tick();
        chk("drain_valid", 32'(b8.out_valid), 32'd0);

        // 1-bit truth tables, in_data = {b, a}
        for (int op = 0; op < 6; op++) begin
            for (int c = 0; c < 4; c++) begin
                a = c[0];
                b = c[1];
                case (op)
                    0: e1 = a & b;
                    1: e1 = a | b;
                    2: e1 = a ^ b;
                    3: e1 = ~(a & b);
                    4: e1 = ~(a | b);
                    default: e1 = ~(a ^ b);
                endcase
                b1.in_valid = 1'b1;
                b1.in_data  = {b, a};
                b1.in_op    = 3'(op);
                b1.in_acc   = 1'b0;
                b1.in_last  = 1'b0;
                tick();
                chk($sformatf("tt_op%0d_c%0d", op, c), 32'(b1.out_data), 32'(e1));
                chk($sformatf("tt_err_op%0d_c%0d", op, c), 32'(b1.out_err), 32'd0);
            end
        end
        b1.in_valid = 1'b0;

        // Accumulate OR over three beats; in_op/in_acc changes mid-packet must be ignored
        beat8(8'h02, 8'h01, 3'd1, 1'b1, 1'b0); tick();
        chk("acc1_valid", 32'(b8.out_valid), 32'd0);
        beat8(8'h08, 8'h04, 3'd0, 1'b0, 1'b0); tick();
        chk("acc2_valid", 32'(b8.out_valid), 32'd0);
        beat8(8'h20, 8'h10, 3'd0, 1'b0, 1'b1); tick();
        chk_out8("acc_or", 8'h3F, 8'd3, 1'b0);

        // XNOR two beats: FF^0F^FF^00 = 0F, inverted F0; first beat also consumes the 3F result
        beat8(8'hFF, 8'h0F, 3'd5, 1'b1, 1'b0); tick();
        chk("accx1_valid", 32'(b8.out_valid), 32'd0);
        beat8(8'hFF, 8'h00, 3'd5, 1'b1, 1'b1); tick();
        chk_out8("acc_xnor", 8'hF0, 8'd2, 1'b0);
        b8.in_valid = 1'b0; tick();

        // Backpressure
        b8.out_ready = 1'b0;
        beat8(8'hA5, 8'h0F, 3'd2, 1'b0, 1'b0); tick();
        chk_out8("bp_first", 8'hAA, 8'd1, 1'b0);
        beat8(8'hF0, 8'hF0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_ready_%0d", i), 32'(b8.in_ready), 32'd0);
            tick();
            chk_out8($sformatf("bp_hold_%0d", i), 8'hAA, 8'd1, 1'b0);
        end
        b8.out_ready = 1'b1; #1;
        chk("bp_release_ready", 32'(b8.in_ready), 32'd1);
        tick();
        chk_out8("bp_next", 8'hF0, 8'd1, 1'b0);
        b8.in_valid = 1'b0; tick();
        chk("bp_drain_valid", 32'(b8.out_valid), 32'd0);

        // Reset mid-packet discards the partial accumulation
        beat8(8'h01, 8'h02, 3'd1, 1'b1, 1'b0); tick();
        beat8(8'h04, 8'h08, 3'd1, 1'b1, 1'b0); tick();
        b8.in_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(b8.out_valid), 32'd0);
        chk("mid_rst_beats", 32'(b8.out_beats), 32'd0);
        beat8(8'h03, 8'h0C, 3'd1, 1'b0, 1'b1); tick();
        chk_out8("post_rst", 8'h0F, 8'd1, 1'b0);

        // Reserved ops
        beat8(8'hFF, 8'hFF, 3'd7, 1'b0, 1'b0); tick();
        chk_out8("rsv7", 8'h00, 8'd1, 1'b1);
        beat8(8'hFF, 8'hFF, 3'd6, 1'b1, 1'b0); tick();
        beat8(8'hFF, 8'hFF, 3'd1, 1'b1, 1'b1); tick();
        chk_out8("rsv6_acc", 8'h00, 8'd2, 1'b1);
        beat8(8'h0F, 8'h3C, 3'd0, 1'b0, 1'b0); tick();
        chk_out8("after_rsv", 8'h0C, 8'd1, 1'b0);

        // Beat counter saturation: 300 beats fold into one result
        beat8(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 299; i++) tick();
        b8.in_last = 1'b1; tick();
        chk_out8("sat", 8'hFF, 8'd255, 1'b0);
        b8.in_valid = 1'b0; tick();
        chk("final_valid", 32'(b8.out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
